// File: rtl/shift_load_ctrl.sv
// Sequencer that serialises a parallel word into an external N-bit shift
// register, then offers the assembled register contents over valid/ready.
module shift_load_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 1,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_dir,
  input  logic          abort,
  output logic          sr_shift_en,
  output logic          sr_dir,
  output logic          sr_d_in,
  input  logic [N-1:0]  sr_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy,
  output logic [CW-1:0] words_done
);

  localparam int BIT_W = $clog2(N);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [N-1:0]     word_q, word_d;
  logic             dir_q, dir_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0] feed_idx;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dir_d   = dir_q;
    bit_d   = bit_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !abort) begin
          word_d  = in_data;
          dir_d   = in_dir;
          bit_d   = '0;
          div_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (div_q == DIV_LAST) begin
          // End of a bit period: advance to the next bit or finish the word.
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      dir_q   <= 1'b0;
      bit_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  // Left shifts take the MSB first, right shifts the LSB first, so the word
  // lands unreversed in the register either way.
  always_comb begin
    feed_idx = dir_q ? bit_q : (BIT_LAST - bit_q);
  end

  assign in_ready    = (state_q == S_IDLE) && !abort;
  assign busy        = (state_q != S_IDLE);
  assign sr_shift_en = (state_q == S_SHIFT) && (div_q == '0);
  assign sr_dir      = dir_q;
  assign sr_d_in     = (state_q == S_SHIFT) && word_q[feed_idx];
  assign out_valid   = (state_q == S_HOLD);
  assign out_data    = out_valid ? sr_q : '0;
  assign words_done  = cnt_q;

endmodule
